btn_debouncer: RTL
==================

# btn_debouncer

Input conditioning stage placed directly upstream of the LED controller top. It takes the raw, asynchronous push-button vector from the board and produces three outputs:
- synchronized, debounced button levels;
- one-cycle rising-edge pulses that the controller consumes as its button commands;
- a priority-resolved one-hot command, so that simultaneous presses never issue conflicting commands.

## Interface
- N_BTN, 4, number of push buttons.
- NB_DEB, 11, width of each per-button debounce counter.
- DEB_CYCLES, 2000, consecutive stable cycles required to accept a level change; legal range 1 .. 2^NB_DEB-1.

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- i_reset  input  1  asynchronous, active-low reset.
- i_btn  input  N_BTN  raw buttons, active-high, asynchronous to clock.
- o_btn_level  output  N_BTN  debounced level per button.
- o_btn_pulse  output  N_BTN  one-cycle pulse per button, high on the first cycle its debounced level is 1.
- o_btn_cmd  output  N_BTN  one-hot copy of the lowest-index bit set in o_btn_pulse; all zeros otherwise.
- o_btn_multi  output  1  high in any cycle where more than one o_btn_pulse bit is set.

## Operation
- **Synchronizer:** per bit, two flops, s1 <= i_btn and s2 <= s1.
- **Debounce state, per button b:** a stable flop stb[b] and a counter cnt[b] of NB_DEB bits.
  - If s2[b] == stb[b]: cnt[b] <= 0.
  - If s2[b] != stb[b] and cnt[b] < DEB_CYCLES-1: cnt[b] <= cnt[b]+1.
  - If s2[b] != stb[b] and cnt[b] == DEB_CYCLES-1: stb[b] <= s2[b] and cnt[b] <= 0.
  - A glitch shorter than DEB_CYCLES cycles at s2 clears the counter and never changes stb.
  - The counter never exceeds DEB_CYCLES-1, so there is no wrap-around.
- **Edge detect:** o_btn_pulse is registered: pulse[b] <= stb_next[b] & ~stb[b], where stb_next is the value being loaded into stb.
  - As a result, pulse and level rise on the same clock edge.
  - Falling edges (release) generate no pulse.
- **Priority resolve:** registered from the same next-state values.
  - cmd = lowest-index set bit of pulse_next.
  - multi = popcount(pulse_next) > 1.
  - Higher-index simultaneous presses are dropped from o_btn_cmd but still visible on o_btn_pulse.
- **Holding a button:** gives exactly one pulse. A new pulse requires the debounced level to fall back to 0 and rise again.
- **Reset (i_reset = 0), asynchronous:**
  - s1, s2, stb, cnt, o_btn_level, o_btn_pulse, o_btn_cmd and o_btn_multi all clear to 0 immediately.
  - Reset asserted mid-debounce discards the partial count.
  - A button still held when reset is released is treated as a fresh press: it pulses once after the normal latency.

## Timing
- **Press latency:** let edge E0 be the first rising clock edge at which s1 samples i_btn = 1.
  - s2 = 1 after E0+1.
  - stb, o_btn_level and o_btn_pulse go high after edge E0+1+DEB_CYCLES.
  - The pulse stays high for exactly one cycle.
- **Release latency:** identical path. o_btn_level falls after edge E0+1+DEB_CYCLES, counted from the first sampled 0.
- o_btn_cmd and o_btn_multi are cycle-aligned with o_btn_pulse.
- **Minimum accepted press width:** DEB_CYCLES+1 clock periods of stable input, allowing for sampling uncertainty.
- **DEB_CYCLES = 1:** stb follows s2 one cycle later, giving a 3-edge total latency from E0.
- All outputs come directly from flops, with no combinational path from i_btn.

## Test plan
Common setup: DEB_CYCLES=4, 10 ns clock.
- **Reset:** hold i_reset=0 with i_btn=4'b1111 for 30 ns, then release -> all outputs 0 during reset; afterwards o_btn_pulse=4'b1111 for one cycle exactly 6 edges after release, with o_btn_cmd=4'b0001 and o_btn_multi=1.
- **Clean press:** i_btn[1]=1, held 200 ns -> one pulse 4'b0010 at E0+5, o_btn_cmd=4'b0010, o_btn_level[1] stays 1, no further pulses; release -> level falls after E0+5, no pulse.
- **Bounce:** toggle i_btn[2] every 20 ns for 100 ns, then hold 1 -> no pulse during bouncing; exactly one pulse 5 edges after the final stable sampling.
- **Double press:** press i_btn[3] for 100 ns, release for 100 ns, press again -> two separate single-cycle pulses on bit 3, with o_btn_level[3] going 1, 0, 1.
- **Simultaneous press:** i_btn[3:2] rise on the same edge -> o_btn_pulse=4'b1100, o_btn_cmd=4'b0100, o_btn_multi=1 for one cycle.
- **Reset mid-debounce:** start a press on bit 0, assert i_reset after 2 edges, release reset while bit 0 is still held -> no pulse before reset; one pulse 6 edges after reset release.

Source files
------------

// File: rtl/btn_debouncer.sv
// Button input conditioning: two-flop synchronizer, per-button debounce,
// rising-edge pulse and lowest-index-wins command resolve. All outputs are registered.

module btn_deb_lane #(
  parameter int NB_DEB     = 11,
  parameter int DEB_CYCLES = 2000
) (
  input  logic clock,
  input  logic i_reset,
  input  logic btn_i,
  output logic level_o,
  output logic level_nxt_o
);
  localparam logic [NB_DEB-1:0] CNT_MAX = NB_DEB'(DEB_CYCLES - 1);

  logic              s1_q, s2_q, stb_q, stb_d;
  logic [NB_DEB-1:0] cnt_q, cnt_d;

  // Any cycle where s2 agrees with the stable level restarts the count,
  // so only an unbroken run of DEB_CYCLES disagreeing cycles is accepted.
  always_comb begin
    stb_d = stb_q;
    cnt_d = '0;
    if (s2_q != stb_q) begin
      if (cnt_q == CNT_MAX) stb_d = s2_q;
      else                  cnt_d = cnt_q + NB_DEB'(1);
    end
  end

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      stb_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q  <= btn_i;
      s2_q  <= s1_q;
      stb_q <= stb_d;
      cnt_q <= cnt_d;
    end
  end

  assign level_o     = stb_q;
  assign level_nxt_o = stb_d;
endmodule

module btn_debouncer #(
  parameter int N_BTN      = 4,
  parameter int NB_DEB     = 11,
  parameter int DEB_CYCLES = 2000
) (
  input  logic             clock,
  input  logic             i_reset,
  input  logic [N_BTN-1:0] i_btn,
  output logic [N_BTN-1:0] o_btn_level,
  output logic [N_BTN-1:0] o_btn_pulse,
  output logic [N_BTN-1:0] o_btn_cmd,
  output logic             o_btn_multi
);
  logic [N_BTN-1:0] lvl_q, lvl_d;
  logic [N_BTN-1:0] pulse_q, pulse_d;
  logic [N_BTN-1:0] cmd_q, cmd_d;
  logic             multi_q, multi_d;

  for (genvar b = 0; b < N_BTN; b++) begin : g_lane
    btn_deb_lane #(
      .NB_DEB     (NB_DEB),
      .DEB_CYCLES (DEB_CYCLES)
    ) u_lane (
      .clock       (clock),
      .i_reset     (i_reset),
      .btn_i       (i_btn[b]),
      .level_o     (lvl_q[b]),
      .level_nxt_o (lvl_d[b])
    );
  end

  // Edge and priority logic use next-state levels so pulse/cmd/multi
  // register on the same edge the level rises.
  always_comb begin
    pulse_d = lvl_d & ~lvl_q;
    cmd_d   = pulse_d & (~pulse_d + N_BTN'(1));
    multi_d = |(pulse_d & (pulse_d - N_BTN'(1)));
  end

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      pulse_q <= '0;
      cmd_q   <= '0;
      multi_q <= 1'b0;
    end else begin
      pulse_q <= pulse_d;
      cmd_q   <= cmd_d;
      multi_q <= multi_d;
    end
  end

  assign o_btn_level = lvl_q;
  assign o_btn_pulse = pulse_q;
  assign o_btn_cmd   = cmd_q;
  assign o_btn_multi = multi_q;
endmodule
